// File: rtl/can_form_pkg.sv
// Shared definitions for the CAN fixed-form field checker.
// Contents: checker state encoding, default EOF/IFS lengths and the
// bus level constants (dominant = 0, recessive = 1).
package can_form_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EOF  = 2'd1,
    IFS  = 2'd2
  } state_t;

  localparam int unsigned CAN_EOF_LEN = 7;
  localparam int unsigned CAN_IFS_LEN = 3;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

endpackage

// File: rtl/can_field_bit_counter.sv
// Bit index counter for fixed-form CAN fields.
// Advances only on sample-point strobes. When clr is set it restarts
// from zero (plus inc, so clr & inc loads 1). last flags that the
// current count equals the runtime last index.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   sp_en        - sample-point strobe qualifying every update
//   clr, inc     - load-to-zero and increment controls
//   last_idx     - index of the final bit of the active field
//   count        - current bit index
//   last         - count == last_idx
module can_field_bit_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sp_en,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] last_idx,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (sp_en) begin
      count <= (clr ? '0 : count) + CNT_W'(inc);
    end
  end

  assign last = (count == last_idx);

endmodule

// File: rtl/can_form_checker.sv
// Fixed-form field checker for the CAN frame decoder: checks the EOF
// field (and, when built with CAN_FORM_IFS_EN, the intermission) on
// sample-point strobes and reports form errors, overload conditions,
// hard-sync SOF and clean completion. All outputs are registered.
// Build option: CAN_FORM_IFS_EN compiles in the IFS state and sof_det;
// without it a clean EOF returns to IDLE and sof_det is tied low.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   sp_en        - sample-point strobe (one clk wide)
//   rx           - destuffed bus level, 0 = dominant
//   field_start  - with sp_en: current sample is EOF bit 0
//   err_clr      - clears err_flag (a simultaneous new error wins)
//   form_err     - pulse: form error
//   err_pos      - bit index of the last form error
//   err_flag     - sticky form error flag
//   overload     - pulse: overload condition
//   sof_det      - pulse: dominant on the last IFS bit
//   done         - pulse: EOF completed cleanly
//   busy         - high while in EOF or IFS
module can_form_checker
  import can_form_pkg::*;
#(
  parameter int unsigned EOF_LEN = CAN_EOF_LEN,
  parameter int unsigned IFS_LEN = CAN_IFS_LEN,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sp_en,
  input  logic             rx,
  input  logic             field_start,
  input  logic             err_clr,
  output logic             form_err,
  output logic [CNT_W-1:0] err_pos,
  output logic             err_flag,
  output logic             overload,
  output logic             sof_det,
  output logic             done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_LEN - 1);
  localparam logic [CNT_W-1:0] IFS_LAST = CNT_W'(IFS_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] last_idx;
  logic             idx_last;
  logic             restart;
  logic             cnt_clr;
  logic             cnt_inc;

  assign restart  = sp_en & field_start;
  assign last_idx = (state == IFS) ? IFS_LAST : EOF_LAST;

  // A start sample is handled as EOF bit 0 right away, so a recessive
  // start leaves the counter at 1 rather than 0.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (restart) begin
      cnt_clr = 1'b1;
      cnt_inc = (rx == RECESSIVE);
    end else if (sp_en && state != IDLE) begin
      if (idx_last || rx == DOMINANT) begin
        cnt_clr = 1'b1;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  can_field_bit_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .sp_en    (sp_en),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .last_idx (last_idx),
    .count    (idx),
    .last     (idx_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      form_err <= 1'b0;
      overload <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err_flag <= 1'b0;
      err_pos  <= '0;
`ifdef CAN_FORM_IFS_EN
      sof_det  <= 1'b0;
`endif
    end else begin
      form_err <= 1'b0;
      overload <= 1'b0;
      done     <= 1'b0;
`ifdef CAN_FORM_IFS_EN
      sof_det  <= 1'b0;
`endif
      // Later err_flag <= 1 assignments override this clear.
      if (err_clr) begin
        err_flag <= 1'b0;
      end

      if (restart) begin
        // EOF_LEN >= 2, so bit 0 is never the last EOF bit.
        if (rx == DOMINANT) begin
          form_err <= 1'b1;
          err_pos  <= '0;
          err_flag <= 1'b1;
          state    <= IDLE;
          busy     <= 1'b0;
        end else begin
          state <= EOF;
          busy  <= 1'b1;
        end
      end else if (sp_en) begin
        case (state)
          EOF: begin
            if (rx == DOMINANT) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (idx_last) begin
                overload <= 1'b1;
              end else begin
                form_err <= 1'b1;
                err_pos  <= idx;
                err_flag <= 1'b1;
              end
            end else if (idx_last) begin
              done <= 1'b1;
`ifdef CAN_FORM_IFS_EN
              state <= IFS;
              busy  <= 1'b1;
`else
              state <= IDLE;
              busy  <= 1'b0;
`endif
            end
          end
`ifdef CAN_FORM_IFS_EN
          IFS: begin
            if (rx == DOMINANT) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (idx_last) begin
                sof_det <= 1'b1;
              end else begin
                overload <= 1'b1;
              end
            end else if (idx_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifndef CAN_FORM_IFS_EN
  assign sof_det = 1'b0;
`endif

endmodule

// File: tb/tb_can_form_checker.sv
module tb_can_form_checker;

  logic       clk = 1'b0;
  logic       reset, sp_en, rx, field_start, err_clr;
  logic       form_err, err_flag, overload, sof_det, done, busy;
  logic [3:0] err_pos;

  always #5 clk = ~clk;

  can_form_checker #(
    .EOF_LEN(7),
    .IFS_LEN(3),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sp_en      (sp_en),
    .rx         (rx),
    .field_start(field_start),
    .err_clr    (err_clr),
    .form_err   (form_err),
    .err_pos    (err_pos),
    .err_flag   (err_flag),
    .overload   (overload),
    .sof_det    (sof_det),
    .done       (done),
    .busy       (busy)
  );

`ifdef CAN_FORM_IFS_EN
  localparam logic IFS_ON = 1'b1;
`else
  localparam logic IFS_ON = 1'b0;
`endif

  // expected = {form_err, overload, sof_det, done, busy, err_flag, err_pos}
  typedef struct {
    logic       rst, sp, rx, fs, clr;
    logic [9:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] sb[$];
  int         checks = 0;
  int         errors = 0;
  logic       finished = 1'b0;

  function void add(input logic rst, sp, rxv, fs, clr,
                    input logic fe, ov, sof, dn, bsy, flag,
                    input logic [3:0] pos);
    vec_t v;
    v.rst = rst; v.sp = sp; v.rx = rxv; v.fs = fs; v.clr = clr;
    v.exp = {fe, ov, sof, dn, bsy, flag, pos};
    vecs.push_back(v);
  endfunction

  // n recessive mid-field samples, busy stays high
  function void mid_bits(input int n, input logic flag, input logic [3:0] pos);
    for (int k = 0; k < n; k++) add(0,1,1,0,0, 0,0,0,0,1,flag,pos);
  endfunction

  // clean intermission after a done pulse (only exists with IFS built in)
  function void clean_tail(input logic flag, input logic [3:0] pos);
    if (IFS_ON) begin
      add(0,1,1,0,0, 0,0,0,0,1,flag,pos);
      add(0,1,1,0,0, 0,0,0,0,1,flag,pos);
      add(0,1,1,0,0, 0,0,0,0,0,flag,pos);
    end
  endfunction

  initial begin
    repeat (2000) @(posedge clk);
    if (!finished) begin
      errors++;
      $display("FAIL timeout: vector stream did not complete within 2000 cycles");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    logic [9:0] got, want;
    reset = 1'b1; sp_en = 1'b0; rx = 1'b1; field_start = 1'b0; err_clr = 1'b0;

    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({form_err, overload, sof_det, done, busy, err_flag, err_pos} !== 10'b0) begin
      errors++;
      $display("FAIL reset state: got %b required %b",
               {form_err, overload, sof_det, done, busy, err_flag, err_pos}, 10'b0);
    end

    // reset, including reset overriding active inputs
    add(1,0,1,0,0, 0,0,0,0,0,0,4'd0);
    add(1,1,0,1,1, 0,0,0,0,0,0,4'd0);
    add(0,0,1,0,0, 0,0,0,0,0,0,4'd0);
    // field_start without sp_en is ignored
    add(0,0,1,1,0, 0,0,0,0,0,0,4'd0);

    // clean EOF with idle gaps between strobes
    add(0,1,1,1,0, 0,0,0,0,1,0,4'd0);
    for (int k = 1; k <= 5; k++) begin
      add(0,1,1,0,0, 0,0,0,0,1,0,4'd0);
      add(0,0,1,0,0, 0,0,0,0,1,0,4'd0);
    end
    add(0,1,1,0,0, 0,0,0,1,IFS_ON,0,4'd0);
    clean_tail(0, 4'd0);
    add(0,0,1,0,0, 0,0,0,0,0,0,4'd0);

    // dominant at EOF bit 3 -> form error
    add(0,1,1,1,0, 0,0,0,0,1,0,4'd0);
    mid_bits(2, 0, 4'd0);
    add(0,1,0,0,0, 1,0,0,0,0,1,4'd3);
    add(0,0,1,0,0, 0,0,0,0,0,1,4'd3);

    // dominant at EOF bit 6 -> overload, flag untouched
    add(0,1,1,1,0, 0,0,0,0,1,1,4'd3);
    mid_bits(5, 1, 4'd3);
    add(0,1,0,0,0, 0,1,0,0,0,1,4'd3);
    add(0,0,1,0,0, 0,0,0,0,0,1,4'd3);

    // err_clr alone
    add(0,0,1,0,1, 0,0,0,0,0,0,4'd3);

    // err_clr together with an EOF bit 2 error: error wins
    add(0,1,1,1,0, 0,0,0,0,1,0,4'd3);
    mid_bits(1, 0, 4'd3);
    add(0,1,0,0,1, 1,0,0,0,0,1,4'd2);
    add(0,0,1,0,0, 0,0,0,0,0,1,4'd2);

    // restart while busy: no pulse, full 7 bits counted from restart
    add(0,1,1,1,0, 0,0,0,0,1,1,4'd2);
    mid_bits(2, 1, 4'd2);
    add(0,1,1,1,0, 0,0,0,0,1,1,4'd2);
    mid_bits(5, 1, 4'd2);
    add(0,1,1,0,0, 0,0,0,1,IFS_ON,1,4'd2);
    clean_tail(1, 4'd2);
    add(0,0,1,0,0, 0,0,0,0,0,1,4'd2);

    // dominant start sample is an error at bit 0
    add(0,1,0,1,0, 1,0,0,0,0,1,4'd0);
    add(0,0,1,0,0, 0,0,0,0,0,1,4'd0);

    // reset at EOF bit 4, then a fresh sequence
    add(0,1,1,1,0, 0,0,0,0,1,1,4'd0);
    mid_bits(3, 1, 4'd0);
    add(1,1,0,0,0, 0,0,0,0,0,0,4'd0);
    add(0,1,1,1,0, 0,0,0,0,1,0,4'd0);
    mid_bits(5, 0, 4'd0);
    add(0,1,1,0,0, 0,0,0,1,IFS_ON,0,4'd0);
    clean_tail(0, 4'd0);
    add(0,0,1,0,0, 0,0,0,0,0,0,4'd0);

`ifdef CAN_FORM_IFS_EN
    // IFS bits 1,1,0 -> hard-sync SOF
    add(0,1,1,1,0, 0,0,0,0,1,0,4'd0);
    mid_bits(5, 0, 4'd0);
    add(0,1,1,0,0, 0,0,0,1,1,0,4'd0);
    mid_bits(2, 0, 4'd0);
    add(0,1,0,0,0, 0,0,1,0,0,0,4'd0);
    add(0,0,1,0,0, 0,0,0,0,0,0,4'd0);
    // IFS bits 1,0 -> overload
    add(0,1,1,1,0, 0,0,0,0,1,0,4'd0);
    mid_bits(5, 0, 4'd0);
    add(0,1,1,0,0, 0,0,0,1,1,0,4'd0);
    mid_bits(1, 0, 4'd0);
    add(0,1,0,0,0, 0,1,0,0,0,0,4'd0);
    add(0,0,1,0,0, 0,0,0,0,0,0,4'd0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      reset       = vecs[i].rst;
      sp_en       = vecs[i].sp;
      rx          = vecs[i].rx;
      field_start = vecs[i].fs;
      err_clr     = vecs[i].clr;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      got  = {form_err, overload, sof_det, done, busy, err_flag, err_pos};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL vec%0d fe/ov/sof/dn/bsy/flag/pos: got %b required %b",
                 i, got, want);
      end
    end

    finished = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_form_checker.md
# can_form_checker

Parametrised fixed-form field checker for the CAN frame decoder. It supersedes the single-purpose EOF checker by adding:
- configurable EOF length;
- overload detection on the last EOF bit;
- optional intermission (IFS) checking;
- error bit position reporting and a sticky error flag.

It sits after the bit-timing/destuffing stage. It samples `rx` on sample-point strobes and reports results to the error-frame generator.

## Interface
Parameters:
- `EOF_LEN`, 7: number of recessive EOF bits (legal 2..15).
- `IFS_LEN`, 3: intermission bits (legal 2..15). Used only with `CAN_FORM_IFS_EN`.
- `CNT_W`, 4: bit-index counter width. Must hold max(`EOF_LEN`, `IFS_LEN`) - 1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `sp_en` in 1: sample-point strobe, one `clk` wide. All bit processing is qualified by it.
- `rx` in 1: destuffed bus level (0 = dominant).
- `field_start` in 1: qualified by `sp_en`. The current sample is EOF bit 0.
- `err_clr` in 1: clears `err_flag`.
- `form_err` out 1: one-cycle pulse, form error detected.
- `err_pos` out `CNT_W`: bit index of the last form error. Holds until the next error or reset.
- `err_flag` out 1: sticky form-error flag.
- `overload` out 1: one-cycle pulse, overload condition.
- `sof_det` out 1: one-cycle pulse, dominant on the last IFS bit (hard-sync SOF).
- `done` out 1: one-cycle pulse, field sequence completed without error.
- `busy` out 1: high while in EOF or IFS.

## Operation
States: IDLE, EOF, IFS. IFS exists only with the macro.

Bit index `idx` advances only on `sp_en`.

IDLE:
- On `sp_en & field_start`, process the current `rx` as EOF `idx`=0.
- Otherwise hold.

EOF, on each `sp_en`:
- `rx`=0 and `idx` < `EOF_LEN`-1: pulse `form_err`, `err_pos`<=`idx`, set `err_flag`, go to IDLE.
- `rx`=0 and `idx` = `EOF_LEN`-1: pulse `overload` (not an error), go to IDLE.
- `rx`=1 and `idx` = `EOF_LEN`-1: pulse `done`, then go to IFS if enabled, else IDLE. `idx`<=0.
- Otherwise `idx`<=`idx`+1.

IFS, on each `sp_en`:
- `rx`=0 and `idx` < `IFS_LEN`-1: pulse `overload`, go to IDLE.
- `rx`=0 and `idx` = `IFS_LEN`-1: pulse `sof_det`, go to IDLE.
- `rx`=1 and `idx` = `IFS_LEN`-1: go to IDLE (bus idle).
- Otherwise `idx`<=`idx`+1.

Boundary and concurrency rules:
- `field_start & sp_en` while `busy`: abort the current sequence and restart at EOF `idx`=0 with the current sample. No pulse is emitted for the aborted sequence.
- `err_clr` in the same cycle as a new error: the error wins and `err_flag` stays 1.
- `sp_en` low: no state, index or output change, except that pulses deassert.
- Index arithmetic is unsigned `CNT_W` bits. It never wraps, because compare-to-last always terminates first.

## Timing
- Reset values (`reset` sampled high at a `clk` edge):
  - state IDLE, `idx` 0;
  - `form_err`, `overload`, `sof_det`, `done`, `busy`, `err_flag` all 0;
  - `err_pos` 0.
- Reset mid-sequence discards it silently. `reset` overrides all other inputs.
- All outputs are registered. A result decided at the `sp_en` cycle-N edge is visible in cycle N+1, for a latency of 1 `clk`.
- Pulses are exactly one `clk` wide regardless of `sp_en` spacing.
- `busy` rises the cycle after the start sample. It falls the cycle after the terminating sample.
- Back-to-back `sp_en` on consecutive `clk` cycles must be supported.

## Configuration
- `CAN_FORM_IFS_EN` defined:
  - IFS state, `IFS_LEN` checking and `sof_det` are compiled in;
  - after a clean EOF the block enters IFS.
- `CAN_FORM_IFS_EN` undefined:
  - no IFS state;
  - a clean EOF returns to IDLE;
  - `sof_det` is tied to 0;
  - `IFS_LEN` is ignored.

## Structure
- Shared package `can_form_pkg`:
  - state enum (IDLE, EOF, IFS);
  - default constants `CAN_EOF_LEN`=7 and `CAN_IFS_LEN`=3;
  - dominant/recessive level constants.
- One sub-module, `can_field_bit_counter`: sp_en-qualified, loadable-to-zero counter with a `last` compare output against a runtime length. It is used for both EOF and IFS indices.

## Test plan
- Clean EOF (`EOF_LEN`=7, 7 recessive samples, IFS disabled) -> `done` pulse one cycle after the 7th sample, no `form_err`, `busy` high for exactly that span.
- Dominant at EOF bit 3 -> `form_err` pulse, `err_pos`=3, `err_flag`=1. A later `err_clr` -> `err_flag`=0.
- Dominant at EOF bit 6 (last) -> `overload` pulse, `form_err`=0, `err_flag` unchanged.
- Macro on, clean EOF, then IFS bits 1,1,0 -> `sof_det` pulse. Separately, IFS bits 1,0 -> `overload` pulse at IFS bit 1.
- `err_clr` asserted in the same cycle as an EOF-bit-2 error -> `err_flag`=1, `err_pos`=2.
- `reset` at EOF bit 4, then `field_start` -> all outputs 0 after reset. The new sequence restarts at `idx` 0 and completes with `done`.
